// File: rtl/instr_prefetch_queue.sv
// Fetch-stage prefetch queue: sequential req/gnt fetch, in-order responses buffered for decode.
// Optional misaligned-redirect fault handling is enabled by defining PFQ_MISALIGN_CHK_EN.
module instr_prefetch_queue #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        instr_misaligned_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned SUM_W = $clog2(DEPTH + MAX_OUTSTANDING + 1);

   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [OUT_W-1:0] outst_q, outst_d;
   logic [OUT_W-1:0] discard_q, discard_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [TAG_W-1:0] tag_rd_q, tag_rd_d;
   logic [TAG_W-1:0] tag_wr_q, tag_wr_d;
   logic [31:0]      q_instr_q [DEPTH];
   logic [31:0]      q_pc_q    [DEPTH];
   logic [31:0]      tag_pc_q  [MAX_OUTSTANDING];

   logic [SUM_W-1:0] occupancy;
   logic             grant, resp, drop, push, pop;
   logic             fault_active;
   logic [31:0]      redirect_tgt;

`ifdef PFQ_MISALIGN_CHK_EN
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {ST_RUN, ST_FAULT} state_e;
   state_e      state_q;
   logic        fault_vld_q;
   logic [31:0] fault_pc_q;

   assign fault_active = (state_q == ST_FAULT);
   assign redirect_tgt = redirect_pc_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_RUN;
         fault_vld_q <= 1'b0;
         fault_pc_q  <= '0;
      end else if (redirect_i) begin
         if (redirect_pc_i[1:0] != 2'b00) begin
            state_q     <= ST_FAULT;
            fault_vld_q <= 1'b1;
            fault_pc_q  <= redirect_pc_i;
         end else begin
            state_q     <= ST_RUN;
            fault_vld_q <= 1'b0;
         end
      end else if (fault_active && fault_vld_q && instr_ready_i) begin
         fault_vld_q <= 1'b0;
      end
   end

   assign instr_valid_o      = fault_active ? fault_vld_q : (count_q != '0);
   assign instr_misaligned_o = fault_active && fault_vld_q;
   assign instr_o            = fault_active ? NOP_INSTR : q_instr_q[rd_ptr_q];
   assign pc_o               = fault_active ? fault_pc_q : q_pc_q[rd_ptr_q];
`else
   assign fault_active       = 1'b0;
   assign redirect_tgt       = redirect_pc_i & 32'hFFFF_FFFC;
   assign instr_valid_o      = (count_q != '0);
   assign instr_misaligned_o = 1'b0;
   assign instr_o            = q_instr_q[rd_ptr_q];
   assign pc_o               = q_pc_q[rd_ptr_q];
`endif

   // Occupancy counts in-flight requests too, so the queue can always absorb every response.
   assign occupancy   = SUM_W'(count_q) + SUM_W'(outst_q);
   assign imem_req_o  = rst_n_i && !redirect_i && !fault_active
                        && (occupancy < SUM_W'(DEPTH))
                        && (outst_q < OUT_W'(MAX_OUTSTANDING));
   assign imem_addr_o = fetch_pc_q;

   assign grant = imem_req_o && imem_gnt_i;
   assign resp  = imem_rvalid_i && (outst_q != '0);
   assign drop  = resp && (discard_q != '0);
   assign push  = resp && !drop && !redirect_i;
   assign pop   = !fault_active && (count_q != '0) && instr_ready_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;

      if (grant) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         tag_wr_d   = (tag_wr_q == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
      end
      if (resp) begin
         tag_rd_d = (tag_rd_q == TAG_W'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      outst_d   = outst_q + OUT_W'(grant) - OUT_W'(resp);
      count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
      discard_d = discard_q - OUT_W'(drop);

      // Everything still in flight after this cycle's accounting returns stale data.
      if (redirect_i) begin
         fetch_pc_d = redirect_tgt;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         discard_d  = outst_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         outst_q    <= '0;
         discard_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_instr_q[PTR_W'(i)] <= '0;
            q_pc_q[PTR_W'(i)]    <= '0;
         end
         for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_pc_q[TAG_W'(i)] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
         if (push) begin
            q_instr_q[wr_ptr_q] <= imem_rdata_i;
            q_pc_q[wr_ptr_q]    <= tag_pc_q[tag_rd_q];
         end
         if (grant) tag_pc_q[tag_wr_q] <= fetch_pc_q;
      end
   end

   a_count_bound:   assert property (@(posedge clk_i) disable iff (!rst_n_i) count_q <= CNT_W'(DEPTH));
   a_outst_bound:   assert property (@(posedge clk_i) disable iff (!rst_n_i) outst_q <= OUT_W'(MAX_OUTSTANDING));
   a_discard_bound: assert property (@(posedge clk_i) disable iff (!rst_n_i) discard_q <= outst_q);
   a_no_overflow:   assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                     !(push && !pop && (count_q == CNT_W'(DEPTH))));

endmodule
